fpu_div_iter: RTL and testbench

//  Iterative, width-parametrised IEEE-754 divider (a/b) for the FPU execute stage.

---
 rtl/fpu_types_pkg.sv | 43 ++++
 rtl/fpu_round.sv | 36 +++
 rtl/fpu_div_iter.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_fpu_div_iter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// Shared FPU types: rounding modes, exception flags, divider FSM states, canonical NaN.
package fpu_types_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } fpu_rm_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fpu_flags_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        ROUND,
        DONE
    } fpu_div_state_t;

    localparam int unsigned NAN_MAX_W = 64;

    // Positive quiet NaN: all-ones exponent, fraction MSB set; upper bits beyond the format are zero.
    function automatic logic [NAN_MAX_W-1:0] canonical_nan(input int unsigned exp_w,
                                                           input int unsigned frac_w);
        logic [NAN_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NAN_MAX_W; i++) begin
            if (i >= frac_w - 1 && i < frac_w + exp_w) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Combinational IEEE rounder: significand plus guard/sticky -> rounded significand, carry, inexact.
module fpu_round
    import fpu_types_pkg::*;
#(
    parameter int unsigned FRAC_W = 10
) (
    input  logic              sign,
    input  logic [FRAC_W:0]   sig_in,
    input  logic              guard,
    input  logic              sticky,
    input  logic [2:0]        rm,
    output logic [FRAC_W:0]   sig_out,
    output logic              carry,
    output logic              inexact
);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    // Pick the increment for the rounding mode and apply it.
    always_comb begin
        inexact = guard | sticky;
        case (rm)
            RM_RNE:  inc = guard & (sticky | sig_in[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            RM_RMM:  inc = guard;
            default: inc = 1'b0;
        endcase
        sum     = {1'b0, sig_in} + {{(FRAC_W+1){1'b0}}, inc};
        sig_out = sum[FRAC_W:0];
        carry   = sum[FRAC_W+1];
    end

endmodule

// File: rtl/fpu_div_iter.sv
// Iterative radix-2 restoring IEEE-754 divider with valid/ready handshake and fflags.
module fpu_div_iter
    import fpu_types_pkg::*;
#(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] opa,
    input  logic [EXP_W+FRAC_W:0] opb,
    input  logic [2:0]            rm,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] result,
    output logic [4:0]            flags
);

    localparam int unsigned FLOAT_W = 1 + EXP_W + FRAC_W;
    localparam int unsigned BIAS    = 2**(EXP_W-1) - 1;
    localparam int unsigned SW      = FRAC_W + 1;
    localparam int unsigned QW      = FRAC_W + 3;
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned LZ_W    = $clog2(SW + 1);
    localparam int unsigned CNT_W   = $clog2(QW);
    localparam logic [NAN_MAX_W-1:0] CNAN_FULL = canonical_nan(EXP_W, FRAC_W);
    localparam logic [FLOAT_W-1:0]   CNAN      = CNAN_FULL[FLOAT_W-1:0];

    typedef struct packed {
        logic          zero;
        logic          inf;
        logic          nan;
        logic          snan;
        logic [SW-1:0] sig;
        logic [EW-1:0] exp;
    } unpk_t;

    // Classify a magnitude and normalise its significand; subnormals get exponent 1-lz.
    function automatic unpk_t unpack(input logic [FLOAT_W-2:0] v);
        unpk_t           u;
        logic [EXP_W-1:0] ef;
        logic [FRAC_W-1:0] ff;
        logic [SW-1:0]    raw;
        logic [LZ_W-1:0]  lz;
        ef  = v[FLOAT_W-2 -: EXP_W];
        ff  = v[FRAC_W-1:0];
        raw = {ef != '0, ff};
        lz  = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (raw[i]) lz = LZ_W'(SW - 1 - i);
        end
        u.zero = (ef == '0) && (ff == '0);
        u.inf  = (ef == '1) && (ff == '0);
        u.nan  = (ef == '1) && (ff != '0);
        u.snan = u.nan && !ff[FRAC_W-1];
        u.sig  = raw << lz;
        u.exp  = EW'((ef == '0) ? EXP_W'(1) : ef) - EW'(lz);
        return u;
    endfunction

    fpu_div_state_t     state_q, state_d;
    logic [FLOAT_W-1:0] a_q, b_q;
    logic [2:0]         rm_q;
    logic               sign_q;
    logic [EW-1:0]      exp_q;
    logic [SW-1:0]      mb_q;
    logic [SW:0]        rem_q;
    logic [QW-1:0]      quo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FLOAT_W-1:0] result_q;
    fpu_flags_t         flags_q;

    unpk_t              ua, ub;
    logic               spec, sign_ab;
    logic [FLOAT_W-1:0] spec_res;
    fpu_flags_t         spec_flags;
    logic [EW-1:0]      e_pre;

    logic               rem_ge;
    logic [SW:0]        rem_sub, rem_next;
    logic [QW-1:0]      quo_next;

    logic [SW-1:0]      r_mant, sub_mant;
    logic               r_guard, r_stk, sub_guard, sub_stk, denorm, tiny, ovf;
    logic [EW-1:0]      r_exp, sh_raw, sh, fin_exp;
    logic [2*SW+1:0]    ext;
    logic [SW-1:0]      nrm_sig, sub_sig, sel_sig;
    logic               nrm_carry, nrm_nx, sub_carry, sub_nx, sel_carry, sel_nx;
    logic [FLOAT_W-1:0] round_res, inf_res, maxf_res;
    fpu_flags_t         round_flags;

    assign result = result_q;
    assign flags  = flags_q;

    // Operand classification and special-case resolution during PREP.
    always_comb begin
        ua         = unpack(a_q[FLOAT_W-2:0]);
        ub         = unpack(b_q[FLOAT_W-2:0]);
        sign_ab    = a_q[FLOAT_W-1] ^ b_q[FLOAT_W-1];
        e_pre      = ua.exp - ub.exp + EW'(BIAS);
        spec       = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (rm_q > 3'd4) begin
            spec_res      = CNAN;
            spec_flags.nv = 1'b1;
        end else if (ua.nan || ub.nan) begin
            spec_res      = CNAN;
            spec_flags.nv = ua.snan || ub.snan;
        end else if ((ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
            spec_res      = CNAN;
            spec_flags.nv = 1'b1;
        end else if (ua.inf) begin
            spec_res = {sign_ab, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (ub.zero) begin
            spec_res      = {sign_ab, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            spec_flags.dz = 1'b1;
        end else if (ua.zero || ub.inf) begin
            spec_res = {sign_ab, {(FLOAT_W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // One restoring-division step: subtract divisor when it fits, shift remainder.
    always_comb begin
        rem_ge   = rem_q >= {1'b0, mb_q};
        rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_next = rem_sub << 1;
        quo_next = {quo_q[QW-2:0], rem_ge};
    end

    // Normalise the quotient to [1,2) and prepare the subnormal (right-shifted) variant.
    always_comb begin
        if (quo_q[QW-1]) begin
            r_mant  = quo_q[QW-1 -: SW];
            r_guard = quo_q[1];
            r_stk   = quo_q[0] | (rem_q != '0);
            r_exp   = exp_q;
        end else begin
            r_mant  = quo_q[QW-2 -: SW];
            r_guard = quo_q[0];
            r_stk   = rem_q != '0;
            r_exp   = exp_q - EW'(1);
        end
        denorm    = r_exp[EW-1] || (r_exp == '0);
        sh_raw    = EW'(1) - r_exp;
        sh        = (sh_raw > EW'(SW + 1)) ? EW'(SW + 1) : sh_raw;
        ext       = {r_mant, r_guard, {(SW+1){1'b0}}} >> sh;
        sub_mant  = ext[2*SW+1 -: SW];
        sub_guard = ext[SW+1];
        sub_stk   = r_stk | (ext[SW:0] != '0);
    end

    // Full-precision rounding: gives normal results and the tininess-after-rounding carry.
    fpu_round #(.FRAC_W(FRAC_W)) u_round_nrm (
        .sign    (sign_q),
        .sig_in  (r_mant),
        .guard   (r_guard),
        .sticky  (r_stk),
        .rm      (rm_q),
        .sig_out (nrm_sig),
        .carry   (nrm_carry),
        .inexact (nrm_nx)
    );

    fpu_round #(.FRAC_W(FRAC_W)) u_round_sub (
        .sign    (sign_q),
        .sig_in  (sub_mant),
        .guard   (sub_guard),
        .sticky  (sub_stk),
        .rm      (rm_q),
        .sig_out (sub_sig),
        .carry   (sub_carry),
        .inexact (sub_nx)
    );

    // Final exponent, overflow handling and flag assembly for the ROUND state.
    always_comb begin
        sel_sig   = denorm ? sub_sig   : nrm_sig;
        sel_carry = denorm ? sub_carry : nrm_carry;
        sel_nx    = denorm ? sub_nx    : nrm_nx;
        // Exponent = base + hidden bit + 2*carry: normal base r_exp-1, subnormal base 0,
        // so a subnormal that rounds up into the hidden bit lands on exponent 1.
        fin_exp   = (denorm ? '0 : (r_exp - EW'(1))) + EW'(sel_sig[FRAC_W])
                    + EW'({sel_carry, 1'b0});
        tiny      = r_exp[EW-1] || ((r_exp == '0) && !nrm_carry);
        ovf       = !fin_exp[EW-1] && (fin_exp >= EW'(2**EXP_W - 1));
        inf_res   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        maxf_res  = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        round_flags = '0;
        if (ovf) begin
            round_flags.of = 1'b1;
            round_flags.nx = 1'b1;
            case (rm_q)
                RM_RTZ:  round_res = maxf_res;
                RM_RDN:  round_res = sign_q ? inf_res : maxf_res;
                RM_RUP:  round_res = sign_q ? maxf_res : inf_res;
                default: round_res = inf_res;
            endcase
        end else begin
            round_res      = {sign_q, fin_exp[EXP_W-1:0], sel_sig[FRAC_W-1:0]};
            round_flags.nx = sel_nx;
            round_flags.uf = tiny && sel_nx;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and handshake outputs; kill returns any busy state to IDLE.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = PREP;
            end
            PREP:    state_d = spec ? DONE : DIV;
            DIV:     if (cnt_q == CNT_W'(QW - 1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill && state_q != IDLE) state_d = IDLE;
    end

    // Datapath registers: operand capture, divider setup, iteration, result.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q  <= opa;
                    b_q  <= opb;
                    rm_q <= rm;
                end
                PREP: begin
                    if (spec) begin
                        result_q <= spec_res;
                        flags_q  <= spec_flags;
                    end else begin
                        sign_q <= sign_ab;
                        exp_q  <= e_pre;
                        mb_q   <= ub.sig;
                        rem_q  <= {1'b0, ua.sig};
                        quo_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ROUND: begin
                    result_q <= round_res;
                    flags_q  <= round_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed self-checking bench for the half-precision divider.
module tb_fpu_div_iter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic [2:0]  rm = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    fpu_div_iter #(.EXP_W(5), .FRAC_W(10)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa       (opa),
        .opb       (opb),
        .rm        (rm),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] r,
                         input string tag);
        int k = 0;
        @(negedge CLK);
        while (!in_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (!in_ready) check({tag, " idle"}, in_ready, 1);
        opa = a; opb = b; rm = r; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        opa = 16'hFFFF; opb = 16'h0000; rm = 3'd7;
    endtask

    // Counts negedges after the handshake edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] r,
                         input logic [15:0] er, input logic [4:0] ef, input int el,
                         input string tag);
        int lat;
        issue(a, b, r, tag);
        wait_out(lat);
        check({tag, " lat"}, lat, el);
        check({tag, " res"}, result, er);
        check({tag, " flg"}, flags, ef);
        consume();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 16'h0000);
        check("rst flags", flags, 5'h00);
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        // Basic, rounding modes, specials, overflow, subnormals.
        do_op(16'h3C00, 16'h4000, 3'd0, 16'h3800, 5'h00, 16, "1/2 rne");
        do_op(16'h3C00, 16'h4200, 3'd0, 16'h3555, 5'h01, 16, "1/3 rne");
        do_op(16'h3C00, 16'h4200, 3'd1, 16'h3555, 5'h01, 16, "1/3 rtz");
        do_op(16'h3C00, 16'h4200, 3'd3, 16'h3556, 5'h01, 16, "1/3 rup");
        do_op(16'h3C00, 16'h4200, 3'd2, 16'h3555, 5'h01, 16, "1/3 rdn");
        do_op(16'h3C00, 16'h4200, 3'd4, 16'h3555, 5'h01, 16, "1/3 rmm");
        do_op(16'h0000, 16'h0000, 3'd0, 16'h7E00, 5'h10, 2,  "0/0");
        do_op(16'h3C00, 16'h0000, 3'd0, 16'h7C00, 5'h08, 2,  "1/0");
        do_op(16'hBC00, 16'h0000, 3'd0, 16'hFC00, 5'h08, 2,  "-1/0");
        do_op(16'h7D00, 16'h3C00, 3'd0, 16'h7E00, 5'h10, 2,  "snan");
        do_op(16'h7E00, 16'h3C00, 3'd0, 16'h7E00, 5'h00, 2,  "qnan");
        do_op(16'h7BFF, 16'h0400, 3'd0, 16'h7C00, 5'h05, 16, "ovf rne");
        do_op(16'h7BFF, 16'h0400, 3'd1, 16'h7BFF, 5'h05, 16, "ovf rtz");
        do_op(16'hFBFF, 16'h0400, 3'd3, 16'hFBFF, 5'h05, 16, "ovf rup neg");
        do_op(16'h0400, 16'h4000, 3'd0, 16'h0200, 5'h00, 16, "sub exact");
        do_op(16'h0001, 16'h3C00, 3'd0, 16'h0001, 5'h00, 16, "min sub");
        do_op(16'h0401, 16'h4000, 3'd0, 16'h0200, 5'h03, 16, "sub tie");
        do_op(16'h0401, 16'h4000, 3'd3, 16'h0201, 5'h03, 16, "sub rup");
        do_op(16'h3C00, 16'h4000, 3'd5, 16'h7E00, 5'h10, 2,  "bad rm");

        // Output back-pressure: result held, no new input accepted.
        issue(16'h3C00, 16'h4000, 3'd0, "stall");
        wait_out(lat);
        check("stall lat", lat, 16);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall res", result, 16'h3800);
            check("stall in_ready", in_ready, 0);
            check("stall out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("release out_valid", out_valid, 0);
        check("release in_ready", in_ready, 1);

        // Kill mid-DIV.
        issue(16'h3C00, 16'h4200, 3'd0, "kill");
        repeat (5) @(negedge CLK);
        kill = 1'b1;
        @(negedge CLK);
        kill = 1'b0;
        check("kill in_ready", in_ready, 1);
        check("kill out_valid", out_valid, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (out_valid) cnt++;
        end
        check("kill no result", cnt, 0);

        // Kill while IDLE does not block a same-cycle handshake.
        @(negedge CLK);
        opa = 16'h3C00; opb = 16'h4000; rm = 3'd0; in_valid = 1'b1; kill = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0; kill = 1'b0; opa = 16'hFFFF; rm = 3'd7;
        wait_out(lat);
        check("idle kill lat", lat, 16);
        check("idle kill res", result, 16'h3800);
        consume();

        // Asynchronous reset mid-DIV.
        issue(16'h3C00, 16'h4200, 3'd0, "reset");
        repeat (6) @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("arst out_valid", out_valid, 0);
        check("arst in_ready", in_ready, 1);
        check("arst result", result, 16'h0000);
        @(negedge CLK);
        nRST = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (out_valid) cnt++;
        end
        check("arst no result", cnt, 0);
        do_op(16'hC000, 16'h3C00, 3'd0, 16'hC000, 5'h00, 16, "after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
